alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 The block SHALL provide port clk_i, input, 1 bit: clock; all state updates on its rising edge.
REQ-003 The block SHALL provide port rst_i, input, 1 bit: synchronous active-high reset.
REQ-004 The block SHALL provide port valid_i, input, 1 bit: operation request, sampled only while ready_o=1.
REQ-005 The block SHALL provide port ALUCtrl_i, input, 3 bits: operation code (010 add, 110 sub, 000 and, 001 or, 011 mul).
REQ-006 The block SHALL provide port data1_i, input, 32 bits: operand A.
REQ-007 The block SHALL provide port data2_i, input, 32 bits: operand B.
REQ-008 The block SHALL provide port ready_o, output, 1 bit: the block accepts a request this cycle.
REQ-009 The block SHALL provide port stall_o, output, 1 bit: multiply in progress; equals NOT ready_o.
REQ-010 The block SHALL provide port valid_o, output, 1 bit: single-cycle pulse marking data_o and zero_o as new.
REQ-011 The block SHALL provide port data_o, output, 32 bits: registered result.
REQ-012 The block SHALL provide port zero_o, output, 1 bit: 1 when the registered result is 0.

Function
REQ-013 The block SHALL use FSM states IDLE and MUL; it SHALL enter MUL only from IDLE on accepted valid_i with ALUCtrl_i=011, and SHALL return to IDLE after iteration 32.
REQ-014 ready_o SHALL be 1 in IDLE and 0 in MUL; valid_i while ready_o=0 SHALL be ignored and not queued.
REQ-015 Non-mul request accepted in cycle N: result registered at edge N; valid_o=1 during cycle N+1 only (latency 1).
REQ-016 Back-to-back non-mul requests SHALL be accepted every cycle, one valid_o pulse per request.
REQ-017 Add/sub SHALL be modulo 2^32 with no overflow flag; sub computes data1_i - data2_i.
REQ-018 Mul SHALL be iterative shift-add: operands latched at acceptance, 6-bit counter, one multiplier bit per cycle, 32 cycles; the result is the low 32 bits of the unsigned product.
REQ-019 Mul accepted in cycle N: valid_o=1 during cycle N+33 only; ready_o returns to 1 in that same cycle.
REQ-020 Operand inputs changing during MUL SHALL NOT affect the result.
REQ-021 Codes 100, 101, 111 SHALL complete with latency 1, data_o=0, zero_o=1, valid_o pulsed.
REQ-022 data_o and zero_o SHALL hold their last value between valid_o pulses.

Reset
REQ-023 rst_i=1 at an edge SHALL force IDLE, counter=0, data_o=0, zero_o=1, valid_o=0, ready_o=1, stall_o=0.
REQ-024 Reset during MUL SHALL abort the multiply with no valid_o pulse; a request in the first cycle after rst_i falls SHALL be accepted.
REQ-025 Reset SHALL take priority over a simultaneous valid_i.

Configuration
REQ-026 When macro ALU_FAST_MUL_EN is defined, mul SHALL use a single-cycle combinational multiplier with latency 1 as in REQ-015, MUL is never entered, and ready_o stays 1 except during reset.
REQ-027 When ALU_FAST_MUL_EN is undefined, mul SHALL follow REQ-018/REQ-019 and no combinational 32x32 multiplier SHALL be instantiated.

Verification
REQ-028 The bench SHALL cover reset: hold rst_i 2 cycles -> data_o=0, zero_o=1, ready_o=1, valid_o=0.
REQ-029 The bench SHALL cover back-to-back ops: add 5+7, then sub 3-5, then or F0|0F on 3 consecutive cycles -> valid_o on 3 consecutive cycles, data_o 0000000C, FFFFFFFE, 000000FF.
REQ-030 The bench SHALL cover a multiply: mul 0x00012345 x 0x00000100 at cycle N -> ready_o=0 for cycles N+1..N+32, valid_o at N+33, data_o 0x01234500.
REQ-031 The bench SHALL cover a request during MUL: add 1+1 on cycle N+5 of an active mul -> ignored; only the mul valid_o pulse appears.
REQ-032 The bench SHALL cover reset mid-multiply: rst_i at cycle N+10 of mul FFFFFFFF x 2 -> no valid_o; add 0+0 next cycle -> valid_o, data_o 0, zero_o 1.
REQ-033 The bench SHALL cover the fast-multiply build: with ALU_FAST_MUL_EN, mul 0xFFFFFFFF x 0xFFFFFFFF -> valid_o next cycle, data_o 0x00000001, ready_o stays 1.

Source files
------------

// File: rtl/alu_seq_if.sv
// Request/response bus of the sequential ALU.
// The requester (master) drives the operation and operands; the ALU (slave)
// answers with ready/stall status and a registered result with a valid pulse.
interface alu_seq_if;
   logic        valid_i;
   logic [2:0]  ALUCtrl_i;
   logic [31:0] data1_i;
   logic [31:0] data2_i;
   logic        ready_o;
   logic        stall_o;
   logic        valid_o;
   logic [31:0] data_o;
   logic        zero_o;

   modport master (
      output valid_i, ALUCtrl_i, data1_i, data2_i,
      input  ready_o, stall_o, valid_o, data_o, zero_o
   );

   modport slave (
      input  valid_i, ALUCtrl_i, data1_i, data2_i,
      output ready_o, stall_o, valid_o, data_o, zero_o
   );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: add, sub, and, or complete in one cycle; mul is an
// iterative shift-add taking 32 cycles, during which new requests are refused.
// Optional build macro ALU_FAST_MUL_EN replaces the iterative multiplier with a
// single-cycle combinational one, so the block never leaves IDLE.
module alu_seq (
   input  logic     clk_i,
   input  logic     rst_i,
   alu_seq_if.slave bus
);

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_MUL = 3'b011;
   localparam logic [2:0] OP_SUB = 3'b110;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_MUL  = 1'b1;

   logic [0:0]  state;
   logic [31:0] alu_result;
   logic [31:0] data_q;
   logic        zero_q;
   logic        valid_q;

`ifndef ALU_FAST_MUL_EN
   logic [5:0]  counter;
   logic [31:0] mul_a;
   logic [31:0] mul_b;
   logic [31:0] mul_acc;
   logic [31:0] mul_next;

   // One shift-add step: add the shifted multiplicand when the current multiplier bit is set
   always_comb begin
      mul_next = mul_acc + (mul_b[0] ? mul_a : 32'd0);
   end
`endif

   // Single-cycle result for every code that does not use the iterative multiplier
   always_comb begin
      alu_result = 32'd0;
      case (bus.ALUCtrl_i)
         OP_ADD:  alu_result = bus.data1_i + bus.data2_i;
         OP_SUB:  alu_result = bus.data1_i - bus.data2_i;
         OP_AND:  alu_result = bus.data1_i & bus.data2_i;
         OP_OR:   alu_result = bus.data1_i | bus.data2_i;
`ifdef ALU_FAST_MUL_EN
         OP_MUL:  alu_result = bus.data1_i * bus.data2_i;
`endif
         default: alu_result = 32'd0;
      endcase
   end

   // Request acceptance, multiply sequencing and the registered result
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state   <= ST_IDLE;
         data_q  <= 32'd0;
         zero_q  <= 1'b1;
         valid_q <= 1'b0;
`ifndef ALU_FAST_MUL_EN
         counter <= 6'd0;
         mul_a   <= 32'd0;
         mul_b   <= 32'd0;
         mul_acc <= 32'd0;
`endif
      end else begin
         valid_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.valid_i) begin
`ifndef ALU_FAST_MUL_EN
                  if (bus.ALUCtrl_i == OP_MUL) begin
                     state   <= ST_MUL;
                     counter <= 6'd0;
                     mul_a   <= bus.data1_i;
                     mul_b   <= bus.data2_i;
                     mul_acc <= 32'd0;
                  end else
`endif
                  begin
                     data_q  <= alu_result;
                     zero_q  <= (alu_result == 32'd0);
                     valid_q <= 1'b1;
                  end
               end
            end
`ifndef ALU_FAST_MUL_EN
            ST_MUL: begin
               if (counter == 6'd31) begin
                  data_q  <= mul_next;
                  zero_q  <= (mul_next == 32'd0);
                  valid_q <= 1'b1;
                  state   <= ST_IDLE;
                  counter <= 6'd0;
               end else begin
                  mul_acc <= mul_next;
                  mul_a   <= {mul_a[30:0], 1'b0};
                  mul_b   <= {1'b0, mul_b[31:1]};
                  counter <= counter + 6'd1;
               end
            end
`endif
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.ready_o = (state == ST_IDLE);
   assign bus.stall_o = (state != ST_IDLE);
   assign bus.valid_o = valid_q;
   assign bus.data_o  = data_q;
   assign bus.zero_o  = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed testbench for alu_seq: reset, back-to-back single-cycle ops,
// iterative multiply timing, ignored requests while busy, reset mid-multiply,
// and the ALU_FAST_MUL_EN build when that macro is defined.
module tb_alu_seq;

   logic clk_i;
   logic rst_i;
   int   assert_count;
   int   fail_count;

   alu_seq_if alu_bus ();

   alu_seq dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (alu_bus)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   task automatic applyStimulus(input logic valid, input logic [2:0] ctrl,
                                input logic [31:0] d1, input logic [31:0] d2);
      alu_bus.valid_i   = valid;
      alu_bus.ALUCtrl_i = ctrl;
      alu_bus.data1_i   = d1;
      alu_bus.data2_i   = d2;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      assert_count++;
      assert (observed === expected) else begin
         fail_count++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Launches a multiply and follows it for 33 cycles; optionally injects an
   // add request in busy cycle 5 and scrambles the operands while busy.
   task automatic runMul(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expected, input bit intrude);
      applyStimulus(1'b1, 3'b011, a, b);
      for (int k = 1; k <= 32; k++) begin
         @(negedge clk_i);
         checkOutput({tag, "_busy_ready"}, {31'd0, alu_bus.ready_o}, 32'd0);
         checkOutput({tag, "_busy_valid"}, {31'd0, alu_bus.valid_o}, 32'd0);
         if (k == 1) checkOutput({tag, "_busy_stall"}, {31'd0, alu_bus.stall_o}, 32'd1);
         if (intrude && k == 5) applyStimulus(1'b1, 3'b010, 32'd1, 32'd1);
         else applyStimulus(1'b0, 3'b010, 32'hDEAD_BEEF, 32'h1357_9BDF);
      end
      @(negedge clk_i);
      checkOutput({tag, "_done_valid"}, {31'd0, alu_bus.valid_o}, 32'd1);
      checkOutput({tag, "_done_ready"}, {31'd0, alu_bus.ready_o}, 32'd1);
      checkOutput({tag, "_done_data"}, alu_bus.data_o, expected);
      checkOutput({tag, "_done_zero"}, {31'd0, alu_bus.zero_o}, {31'd0, expected == 32'd0});
      @(negedge clk_i);
      checkOutput({tag, "_after_valid"}, {31'd0, alu_bus.valid_o}, 32'd0);
      checkOutput({tag, "_after_hold"}, alu_bus.data_o, expected);
   endtask

   // Linear sequence of directed steps; inputs change and outputs are sampled on falling edges
   initial begin
      assert_count = 0;
      fail_count   = 0;
      rst_i = 1'b1;
      applyStimulus(1'b0, 3'b000, 32'd0, 32'd0);

      // Reset held for two rising edges
      repeat (2) @(negedge clk_i);
      checkOutput("rst_data",  alu_bus.data_o, 32'd0);
      checkOutput("rst_zero",  {31'd0, alu_bus.zero_o}, 32'd1);
      checkOutput("rst_ready", {31'd0, alu_bus.ready_o}, 32'd1);
      checkOutput("rst_stall", {31'd0, alu_bus.stall_o}, 32'd0);
      checkOutput("rst_valid", {31'd0, alu_bus.valid_o}, 32'd0);

      // Back-to-back add, sub, or
      rst_i = 1'b0;
      applyStimulus(1'b1, 3'b010, 32'd5, 32'd7);
      @(negedge clk_i);
      checkOutput("add_valid", {31'd0, alu_bus.valid_o}, 32'd1);
      checkOutput("add_data", alu_bus.data_o, 32'h0000_000C);
      checkOutput("add_zero", {31'd0, alu_bus.zero_o}, 32'd0);
      applyStimulus(1'b1, 3'b110, 32'd3, 32'd5);
      @(negedge clk_i);
      checkOutput("sub_valid", {31'd0, alu_bus.valid_o}, 32'd1);
      checkOutput("sub_data", alu_bus.data_o, 32'hFFFF_FFFE);
      applyStimulus(1'b1, 3'b001, 32'h0000_00F0, 32'h0000_000F);
      @(negedge clk_i);
      checkOutput("or_valid", {31'd0, alu_bus.valid_o}, 32'd1);
      checkOutput("or_data", alu_bus.data_o, 32'h0000_00FF);
      applyStimulus(1'b0, 3'b010, 32'd9, 32'd9);
      @(negedge clk_i);
      checkOutput("idle_valid", {31'd0, alu_bus.valid_o}, 32'd0);
      checkOutput("idle_hold", alu_bus.data_o, 32'h0000_00FF);

      // And, add wrap-around to zero, and an unsupported code
      applyStimulus(1'b1, 3'b000, 32'h0000_FF00, 32'h0000_0F0F);
      @(negedge clk_i);
      checkOutput("and_data", alu_bus.data_o, 32'h0000_0F00);
      applyStimulus(1'b1, 3'b010, 32'hFFFF_FFFF, 32'd1);
      @(negedge clk_i);
      checkOutput("addwrap_data", alu_bus.data_o, 32'd0);
      checkOutput("addwrap_zero", {31'd0, alu_bus.zero_o}, 32'd1);
      applyStimulus(1'b1, 3'b001, 32'h0000_0001, 32'd0);
      @(negedge clk_i);
      checkOutput("or1_zero", {31'd0, alu_bus.zero_o}, 32'd0);
      applyStimulus(1'b1, 3'b101, 32'h1234_5678, 32'h1111_1111);
      @(negedge clk_i);
      checkOutput("bad_valid", {31'd0, alu_bus.valid_o}, 32'd1);
      checkOutput("bad_data", alu_bus.data_o, 32'd0);
      checkOutput("bad_zero", {31'd0, alu_bus.zero_o}, 32'd1);

`ifdef ALU_FAST_MUL_EN
      // Single-cycle multiply
      applyStimulus(1'b1, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      @(negedge clk_i);
      checkOutput("fmul_valid", {31'd0, alu_bus.valid_o}, 32'd1);
      checkOutput("fmul_data", alu_bus.data_o, 32'h0000_0001);
      checkOutput("fmul_ready", {31'd0, alu_bus.ready_o}, 32'd1);
      applyStimulus(1'b1, 3'b011, 32'h0001_2345, 32'h0000_0100);
      @(negedge clk_i);
      checkOutput("fmul2_data", alu_bus.data_o, 32'h0123_4500);
      checkOutput("fmul2_ready", {31'd0, alu_bus.ready_o}, 32'd1);
      applyStimulus(1'b0, 3'b000, 32'd0, 32'd0);
      @(negedge clk_i);
`else
      // Iterative multiplies, the first with an ignored add in busy cycle 5
      runMul("mul", 32'h0001_2345, 32'h0000_0100, 32'h0123_4500, 1'b1);
      runMul("mulff", 32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF, 1'b0);
      runMul("mulb31", 32'h0000_0003, 32'h8000_0001, 32'h8000_0003, 1'b0);
      runMul("mul0", 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 1'b0);

      // Reset in busy cycle 10 aborts the multiply
      applyStimulus(1'b1, 3'b011, 32'hFFFF_FFFF, 32'd2);
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk_i);
         if (k == 1) applyStimulus(1'b0, 3'b011, 32'hFFFF_FFFF, 32'd2);
         if (k == 10) rst_i = 1'b1;
      end
      @(negedge clk_i);
      checkOutput("abort_valid", {31'd0, alu_bus.valid_o}, 32'd0);
      checkOutput("abort_ready", {31'd0, alu_bus.ready_o}, 32'd1);
      checkOutput("abort_stall", {31'd0, alu_bus.stall_o}, 32'd0);
      checkOutput("abort_data", alu_bus.data_o, 32'd0);
      rst_i = 1'b0;
      applyStimulus(1'b1, 3'b010, 32'd0, 32'd0);
      @(negedge clk_i);
      checkOutput("postrst_valid", {31'd0, alu_bus.valid_o}, 32'd1);
      checkOutput("postrst_data", alu_bus.data_o, 32'd0);
      checkOutput("postrst_zero", {31'd0, alu_bus.zero_o}, 32'd1);
      applyStimulus(1'b0, 3'b010, 32'd0, 32'd0);
      for (int k = 0; k < 30; k++) begin
         @(negedge clk_i);
         checkOutput("postrst_quiet", {31'd0, alu_bus.valid_o}, 32'd0);
      end
`endif

      // Load a nonzero result, then reset wins over a simultaneous request
      applyStimulus(1'b1, 3'b010, 32'd5, 32'd7);
      @(negedge clk_i);
      checkOutput("prerst_data", alu_bus.data_o, 32'h0000_000C);
      rst_i = 1'b1;
      applyStimulus(1'b1, 3'b010, 32'd5, 32'd7);
      @(negedge clk_i);
      checkOutput("rstprio_valid", {31'd0, alu_bus.valid_o}, 32'd0);
      checkOutput("rstprio_data", alu_bus.data_o, 32'd0);
      checkOutput("rstprio_zero", {31'd0, alu_bus.zero_o}, 32'd1);
      rst_i = 1'b0;
      applyStimulus(1'b0, 3'b000, 32'd0, 32'd0);
      @(negedge clk_i);

      $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
      $finish;
   end

endmodule
